// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder (subtractor when BCD_SUBTRACT_EN is defined), one digit per clock, LSD first.
// Latency: done pulses DIGITS cycles after the accepting edge; start is ignored while busy.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  MAX10_CLK1_50,
    input  logic                  RESET_N,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
`ifdef BCD_SUBTRACT_EN
    input  logic                  sub,
`endif
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [W-1:0]    a_l;
    logic [W-1:0]    b_l;
    logic [W-1:0]    acc;
    logic [W-1:0]    acc_nxt;
    logic            carry;
    logic [3:0]      da;
    logic [3:0]      db;
    logic [3:0]      dsum;
    logic            c_nxt;
    logic [4:0]      t_add;
`ifdef BCD_SUBTRACT_EN
    logic            sub_l;
    logic [5:0]      t_sub;
`endif

    function automatic logic bad_digits(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    always_comb begin
        da      = a_l[int'(idx)*4 +: 4];
        db      = b_l[int'(idx)*4 +: 4];
        t_add   = {1'b0, da} + {1'b0, db} + {4'b0, carry};
        dsum    = t_add[3:0];
        c_nxt   = 1'b0;
        if (t_add > 5'd9) begin
            dsum  = t_add[3:0] + 4'd6;
            c_nxt = 1'b1;
        end
`ifdef BCD_SUBTRACT_EN
        t_sub = {2'b0, da} - {2'b0, db} - {5'b0, carry};
        if (sub_l) begin
            // Negative digit difference borrows ten from the next digit
            dsum  = t_sub[5] ? (t_sub[3:0] + 4'd10) : t_sub[3:0];
            c_nxt = t_sub[5];
        end
`endif
        acc_nxt = acc;
        acc_nxt[int'(idx)*4 +: 4] = dsum;
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            idx   <= '0;
            a_l   <= '0;
            b_l   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
`ifdef BCD_SUBTRACT_EN
            sub_l <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_l   <= a;
                        b_l   <= b;
                        carry <= cin;
`ifdef BCD_SUBTRACT_EN
                        sub_l <= sub;
`endif
                        idx   <= '0;
                        acc   <= '0;
                        err   <= bad_digits(a) | bad_digits(b);
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    carry <= c_nxt;
                    // Result is published only on the last digit so sum never shows partial work
                    if (idx == IW'(DIGITS - 1)) begin
                        sum   <= acc_nxt;
                        cout  <= c_nxt;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
